// File: rtl/counter_multi_if.sv
// counter_multi_if: bundles the shared tick, per-channel control strobes, periods
// and per-channel status of the counter_multi timer block.
// The master side drives control and period. The slave side is the timer itself.
// Optional capture signals appear only when COUNTER_MULTI_CAPTURE_EN is defined.
interface counter_multi_if #(
    parameter int WIDTH = 32,
    parameter int CH    = 4
);
    logic                timer_tick;
    logic [CH-1:0]       start;
    logic [CH-1:0]       stop;
    logic [CH-1:0]       reload;
    logic [CH*WIDTH-1:0] N;
    logic [CH*WIDTH-1:0] count;
    logic [CH-1:0]       busy;
    logic [CH-1:0]       done;
    logic [CH-1:0]       zero;
`ifdef COUNTER_MULTI_CAPTURE_EN
    logic [CH-1:0]       capture;
    logic [CH*WIDTH-1:0] capture_val;
    logic [CH-1:0]       capture_valid;

    modport master (
        output timer_tick, start, stop, reload, N, capture,
        input  count, busy, done, zero, capture_val, capture_valid
    );
    modport slave (
        input  timer_tick, start, stop, reload, N, capture,
        output count, busy, done, zero, capture_val, capture_valid
    );
`else
    modport master (
        output timer_tick, start, stop, reload, N,
        input  count, busy, done, zero
    );
    modport slave (
        input  timer_tick, start, stop, reload, N,
        output count, busy, done, zero
    );
`endif
endinterface

// File: rtl/counter_multi.sv
// counter_multi: CH independent programmable down-counters sharing one tick enable.
// Each channel loads a period N on start and counts down on ticks while in RUN.
// At terminal count the channel pulses done. It then either stops (one-shot) or
// reloads its latched period (auto-reload).
// Optional feature macro: COUNTER_MULTI_CAPTURE_EN adds per-channel count capture.
module counter_multi #(
    parameter int WIDTH = 32,
    parameter int CH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    counter_multi_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q  [CH];
    state_t           state_d  [CH];
    logic [WIDTH-1:0] count_q  [CH];
    logic [WIDTH-1:0] count_d  [CH];
    logic [WIDTH-1:0] period_q [CH];
    logic [WIDTH-1:0] period_d [CH];
    logic             mode_q   [CH];
    logic             mode_d   [CH];
    logic [CH-1:0]    done_q;
    logic [CH-1:0]    done_d;

    // Per-channel next state. Priority is start over stop over tick, and RUN never keeps count 0.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            state_d[i]  = state_q[i];
            count_d[i]  = count_q[i];
            period_d[i] = period_q[i];
            mode_d[i]   = mode_q[i];
            done_d[i]   = 1'b0;
            if (bus.start[i]) begin
                period_d[i] = bus.N[i*WIDTH +: WIDTH];
                mode_d[i]   = bus.reload[i];
                count_d[i]  = bus.N[i*WIDTH +: WIDTH];
                state_d[i]  = (bus.N[i*WIDTH +: WIDTH] != '0) ? RUN : IDLE;
            end else if (bus.stop[i]) begin
                state_d[i]  = IDLE;
            end else if ((state_q[i] == RUN) && bus.timer_tick) begin
                if (count_q[i] > WIDTH'(1)) begin
                    count_d[i] = count_q[i] - WIDTH'(1);
                end else begin
                    done_d[i] = 1'b1;
                    if (mode_q[i]) begin
                        count_d[i] = period_q[i];
                    end else begin
                        count_d[i] = '0;
                        state_d[i] = IDLE;
                    end
                end
            end
        end
    end

    // Channel state registers with synchronous reset. A reset mid-run drops done silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                state_q[i]  <= IDLE;
                count_q[i]  <= '0;
                period_q[i] <= '0;
                mode_q[i]   <= 1'b0;
            end
            done_q <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                state_q[i]  <= state_d[i];
                count_q[i]  <= count_d[i];
                period_q[i] <= period_d[i];
                mode_q[i]   <= mode_d[i];
            end
            done_q <= done_d;
        end
    end

    // Status outputs are decoded straight from the registers with no added latency.
    always_comb begin
        bus.count = '0;
        bus.busy  = '0;
        bus.zero  = '0;
        bus.done  = done_q;
        for (int i = 0; i < CH; i++) begin
            bus.count[i*WIDTH +: WIDTH] = count_q[i];
            bus.busy[i]                 = (state_q[i] == RUN);
            bus.zero[i]                 = (count_q[i] == '0);
        end
    end

`ifdef COUNTER_MULTI_CAPTURE_EN
    logic [WIDTH-1:0] cap_val_q [CH];
    logic [CH-1:0]    cap_valid_q;

    // Capture snapshots the pre-edge count. A start clears the valid flag unless capture is also asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                cap_val_q[i] <= '0;
            end
            cap_valid_q <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (bus.capture[i]) begin
                    cap_val_q[i]   <= count_q[i];
                    cap_valid_q[i] <= 1'b1;
                end else if (bus.start[i]) begin
                    cap_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // Pack the captured values onto the flat output bus.
    always_comb begin
        bus.capture_val   = '0;
        bus.capture_valid = cap_valid_q;
        for (int i = 0; i < CH; i++) begin
            bus.capture_val[i*WIDTH +: WIDTH] = cap_val_q[i];
        end
    end
`else
    // Capture logic is not built in this configuration.
`endif

endmodule

// File: tb/tb_counter_multi.sv
// tb_counter_multi: directed table-driven bench for counter_multi (WIDTH=32, CH=4).
// The bench also runs hand sequences for the auto-reload period and, when
// COUNTER_MULTI_CAPTURE_EN is defined, for the capture path.
module tb_counter_multi;

    localparam int WIDTH = 32;
    localparam int CH    = 4;

    logic clk = 1'b0;
    logic rst;

    counter_multi_if #(.WIDTH(WIDTH), .CH(CH)) bus ();

    counter_multi #(.WIDTH(WIDTH), .CH(CH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         rst;
        logic         tick;
        logic [3:0]   start;
        logic [3:0]   stop;
        logic [3:0]   reload;
        logic [127:0] n;
        logic [127:0] exp_count;
        logic [3:0]   exp_busy;
        logic [3:0]   exp_done;
        logic [3:0]   exp_zero;
    } vec_t;

    vec_t vecs[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    function automatic logic [127:0] p4(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    task automatic addVec(input string name, input logic r, input logic t,
                          input logic [3:0] st, input logic [3:0] sp, input logic [3:0] rl,
                          input logic [127:0] n, input logic [127:0] c,
                          input logic [3:0] b, input logic [3:0] d, input logic [3:0] z);
        vec_t v;
        v.name = name; v.rst = r; v.tick = t; v.start = st; v.stop = sp; v.reload = rl;
        v.n = n; v.exp_count = c; v.exp_busy = b; v.exp_done = d; v.exp_zero = z;
        vecs.push_back(v);
    endtask

    task automatic checkVal(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [127:0] c,
                               input logic [3:0] b, input logic [3:0] d, input logic [3:0] z);
        checkVal({name, "/count"}, bus.count, c);
        checkVal({name, "/busy"},  {124'd0, bus.busy}, {124'd0, b});
        checkVal({name, "/done"},  {124'd0, bus.done}, {124'd0, d});
        checkVal({name, "/zero"},  {124'd0, bus.zero}, {124'd0, z});
    endtask

    task automatic applyStimulus(input vec_t v);
        rst            = v.rst;
        bus.timer_tick = v.tick;
        bus.start      = v.start;
        bus.stop       = v.stop;
        bus.reload     = v.reload;
        bus.N          = v.n;
        @(posedge clk);
        #1;
    endtask

    // Clock edges with current inputs until done[ch] is seen; returns -1 if the bound expires.
    task automatic waitDone(input int ch, input int bound, output int cycles);
        cycles = -1;
        for (int k = 1; k <= bound; k++) begin
            @(posedge clk);
            #1;
            if (bus.done[ch] === 1'b1) begin
                cycles = k;
                break;
            end
        end
    endtask

    initial begin
        logic [127:0] z;
        int ar_cnt [15];
        int cyc;
        z = '0;
        ar_cnt = '{3, 3, 2, 2, 1, 1, 4, 4, 3, 3, 2, 2, 1, 1, 4};

        rst = 1'b1;
        bus.timer_tick = 1'b0;
        bus.start = '0;
        bus.stop = '0;
        bus.reload = '0;
        bus.N = '0;
`ifdef COUNTER_MULTI_CAPTURE_EN
        bus.capture = '0;
`endif

        // Reset and ignored ticks in IDLE
        addVec("rst1",      1, 0, 4'b0000, 4'b0000, 4'b0000, z, z, 4'b0000, 4'b0000, 4'b1111);
        addVec("rst2",      1, 1, 4'b0000, 4'b0000, 4'b0000, z, z, 4'b0000, 4'b0000, 4'b1111);
        addVec("idle_tick", 0, 1, 4'b0000, 4'b0000, 4'b0000, z, z, 4'b0000, 4'b0000, 4'b1111);
        // One-shot ch0, N=3
        addVec("os_start", 0, 1, 4'b0001, 4'b0000, 4'b0000, p4(3,0,0,0), p4(3,0,0,0), 4'b0001, 4'b0000, 4'b1110);
        addVec("os_t1",    0, 1, 4'b0000, 4'b0000, 4'b0000, z, p4(2,0,0,0), 4'b0001, 4'b0000, 4'b1110);
        addVec("os_t2",    0, 1, 4'b0000, 4'b0000, 4'b0000, z, p4(1,0,0,0), 4'b0001, 4'b0000, 4'b1110);
        addVec("os_t3",    0, 1, 4'b0000, 4'b0000, 4'b0000, z, z, 4'b0000, 4'b0001, 4'b1111);
        addVec("os_after", 0, 1, 4'b0000, 4'b0000, 4'b0000, z, z, 4'b0000, 4'b0000, 4'b1111);
        // Auto-reload ch1, N=4, tick every second cycle, N changed to 7 mid-run
        addVec("ar_start", 0, 0, 4'b0010, 4'b0000, 4'b0010, p4(0,4,0,0), p4(0,4,0,0), 4'b0010, 4'b0000, 4'b1101);
        for (int k = 1; k <= 15; k++) begin
            addVec($sformatf("ar_step%0d", k), 0, (k % 2 == 1), 4'b0000, 4'b0000, 4'b0000,
                   (k >= 6) ? p4(0,7,0,0) : z, p4(0, ar_cnt[k-1], 0, 0), 4'b0010,
                   (k == 7 || k == 15) ? 4'b0010 : 4'b0000, 4'b1101);
        end
        addVec("ar_stop",  0, 1, 4'b0000, 4'b0010, 4'b0000, z, p4(0,4,0,0), 4'b0000, 4'b0000, 4'b1101);
        // Boundaries on ch2
        addVec("n0_start",   0, 1, 4'b0100, 4'b0000, 4'b0000, z, p4(0,4,0,0), 4'b0000, 4'b0000, 4'b1101);
        addVec("start_stop", 0, 0, 4'b0100, 4'b0100, 4'b0000, p4(0,0,5,0), p4(0,4,5,0), 4'b0100, 4'b0000, 4'b1001);
        addVec("bd_t1",      0, 1, 4'b0000, 4'b0000, 4'b0000, z, p4(0,4,4,0), 4'b0100, 4'b0000, 4'b1001);
        addVec("bd_t2",      0, 1, 4'b0000, 4'b0000, 4'b0000, z, p4(0,4,3,0), 4'b0100, 4'b0000, 4'b1001);
        addVec("bd_t3",      0, 1, 4'b0000, 4'b0000, 4'b0000, z, p4(0,4,2,0), 4'b0100, 4'b0000, 4'b1001);
        addVec("restart9",   0, 1, 4'b0100, 4'b0000, 4'b0000, p4(0,0,9,0), p4(0,4,9,0), 4'b0100, 4'b0000, 4'b1001);
        addVec("rs_t1",      0, 1, 4'b0000, 4'b0000, 4'b0000, z, p4(0,4,8,0), 4'b0100, 4'b0000, 4'b1001);
        addVec("rs_t2",      0, 1, 4'b0000, 4'b0000, 4'b0000, z, p4(0,4,7,0), 4'b0100, 4'b0000, 4'b1001);
        addVec("rs_t3",      0, 1, 4'b0000, 4'b0000, 4'b0000, z, p4(0,4,6,0), 4'b0100, 4'b0000, 4'b1001);
        addVec("rs_t4",      0, 1, 4'b0000, 4'b0000, 4'b0000, z, p4(0,4,5,0), 4'b0100, 4'b0000, 4'b1001);
        addVec("stop5",      0, 1, 4'b0000, 4'b0100, 4'b0000, z, p4(0,4,5,0), 4'b0000, 4'b0000, 4'b1001);
        addVec("frozen5",    0, 1, 4'b0000, 4'b0000, 4'b0000, z, p4(0,4,5,0), 4'b0000, 4'b0000, 4'b1001);
        addVec("rst3",       1, 0, 4'b0000, 4'b0000, 4'b0000, z, z, 4'b0000, 4'b0000, 4'b1111);
        // Independence: N=1,2,3,4, ch1/ch3 auto-reload, reset at tick 3
        addVec("ind_start", 0, 1, 4'b1111, 4'b0000, 4'b1010, p4(1,2,3,4), p4(1,2,3,4), 4'b1111, 4'b0000, 4'b0000);
        addVec("ind_t1",    0, 1, 4'b0000, 4'b0000, 4'b0000, z, p4(0,1,2,3), 4'b1110, 4'b0001, 4'b0001);
        addVec("ind_t2",    0, 1, 4'b0000, 4'b0000, 4'b0000, z, p4(0,2,1,2), 4'b1110, 4'b0010, 4'b0001);
        addVec("ind_rst",   1, 1, 4'b0000, 4'b0000, 4'b0000, z, z, 4'b0000, 4'b0000, 4'b1111);
        // Same launch, run to tick 4 without reset
        addVec("ind2_start", 0, 1, 4'b1111, 4'b0000, 4'b1010, p4(1,2,3,4), p4(1,2,3,4), 4'b1111, 4'b0000, 4'b0000);
        addVec("ind2_t1",    0, 1, 4'b0000, 4'b0000, 4'b0000, z, p4(0,1,2,3), 4'b1110, 4'b0001, 4'b0001);
        addVec("ind2_t2",    0, 1, 4'b0000, 4'b0000, 4'b0000, z, p4(0,2,1,2), 4'b1110, 4'b0010, 4'b0001);
        addVec("ind2_t3",    0, 1, 4'b0000, 4'b0000, 4'b0000, z, p4(0,1,0,1), 4'b1010, 4'b0100, 4'b0101);
        addVec("ind2_t4",    0, 1, 4'b0000, 4'b0000, 4'b0000, z, p4(0,2,0,4), 4'b1010, 4'b1010, 4'b0101);
        addVec("ind2_rst",   1, 0, 4'b0000, 4'b0000, 4'b0000, z, z, 4'b0000, 4'b0000, 4'b1111);
        // Maximum period
        addVec("max_start", 0, 0, 4'b0001, 4'b0000, 4'b0000, p4(32'hFFFF_FFFF,0,0,0), p4(32'hFFFF_FFFF,0,0,0), 4'b0001, 4'b0000, 4'b1110);
        addVec("max_t1",    0, 1, 4'b0000, 4'b0000, 4'b0000, z, p4(32'hFFFF_FFFE,0,0,0), 4'b0001, 4'b0000, 4'b1110);
        addVec("max_stop",  0, 1, 4'b0000, 4'b0001, 4'b0000, z, p4(32'hFFFF_FFFE,0,0,0), 4'b0000, 4'b0000, 4'b1110);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i].name, vecs[i].exp_count, vecs[i].exp_busy, vecs[i].exp_done, vecs[i].exp_zero);
        end

        // Auto-reload ch3 with N=5 and continuous ticks: done after 5 ticks, then every 5
        rst = 1'b0;
        bus.timer_tick = 1'b1;
        bus.start = 4'b1000;
        bus.stop = '0;
        bus.reload = 4'b1000;
        bus.N = p4(0,0,0,5);
        @(posedge clk);
        #1;
        bus.start = '0;
        waitDone(3, 20, cyc);
        checkVal("reload_first_done", cyc, 5);
        waitDone(3, 20, cyc);
        checkVal("reload_period", cyc, 5);
        checkVal("reload_count", bus.count, p4(32'hFFFF_FFFE,0,0,5));

`ifdef COUNTER_MULTI_CAPTURE_EN
        // Capture ch0 at count 6 from N=10, then check stickiness and clearing by start
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkVal("cap_reset_valid", {124'd0, bus.capture_valid}, 128'd0);
        bus.timer_tick = 1'b1;
        bus.start = 4'b0001;
        bus.reload = '0;
        bus.N = p4(10,0,0,0);
        @(posedge clk);
        #1;
        bus.start = '0;
        repeat (4) @(posedge clk);
        #1;
        checkVal("cap_pre_count", bus.count, p4(6,0,0,0));
        bus.capture = 4'b0001;
        @(posedge clk);
        #1;
        bus.capture = '0;
        checkVal("cap_val", bus.capture_val, p4(6,0,0,0));
        checkVal("cap_valid", {124'd0, bus.capture_valid}, {124'd0, 4'b0001});
        checkVal("cap_count_after", bus.count, p4(5,0,0,0));
        @(posedge clk);
        #1;
        checkVal("cap_sticky", {124'd0, bus.capture_valid}, {124'd0, 4'b0001});
        bus.start = 4'b0001;
        bus.N = p4(3,0,0,0);
        @(posedge clk);
        #1;
        checkVal("cap_cleared", {124'd0, bus.capture_valid}, 128'd0);
        bus.capture = 4'b0001;
        bus.N = p4(8,0,0,0);
        @(posedge clk);
        #1;
        bus.start = '0;
        bus.capture = '0;
        checkVal("cap_wins_valid", {124'd0, bus.capture_valid}, {124'd0, 4'b0001});
        checkVal("cap_wins_val", bus.capture_val, p4(3,0,0,0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/counter_multi.md
Name: counter_multi

Overview:
- Multi-channel, parametrised programmable down-counter/timer.
- Each channel loads a period N, decrements on a shared tick enable, and flags terminal count.
- Each channel runs either one-shot or auto-reload (periodic).
- Used for timed triggers, gating windows and periodic events driven from a common prescaled tick.

Parameters:
- WIDTH, 32, bit width of each channel's counter and period.
- CH, 4, number of independent channels.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- timer_tick  in  1  shared decrement enable; one-cycle qualifier, not a clock.
- start  in  CH  per-channel load/launch strobe.
- stop  in  CH  per-channel abort strobe.
- reload  in  CH  per-channel mode: 1 = auto-reload, 0 = one-shot; sampled at start.
- N  in  CH*WIDTH  per-channel period; channel i uses bits [i*WIDTH +: WIDTH].
- count  out  CH*WIDTH  current count per channel, registered.
- busy  out  CH  channel is in RUN.
- done  out  CH  one-clk pulse at terminal count.
- zero  out  CH  level, count == 0.

Behaviour:
- Per-channel FSM with states IDLE and RUN; channels are fully independent.
- Per-channel registers: count, period_reg, mode_reg, state.
- Reset (rst=1 at a clk edge), all channels:
  - count=0, period_reg=0, mode_reg=0, state=IDLE.
  - busy=0, done=0, zero=1.
  - Reset mid-run aborts silently with no done pulse.
- Priority per channel at each edge: rst > start > stop > timer_tick.
- start[i], accepted in any state:
  - period_reg<=N_i, mode_reg<=reload[i], count<=N_i.
  - If N_i != 0: state<=RUN. If N_i == 0: state<=IDLE, no done pulse.
  - busy is visible the cycle after the start edge.
  - A start in RUN restarts cleanly with the new N; any tick in the same cycle is ignored.
- stop[i]: state<=IDLE, count frozen at its current value, no done pulse.
- RUN with timer_tick=1:
  - count > 1: count<=count-1.
  - count == 1, mode_reg=0: count<=0, state<=IDLE, done[i]=1 for one cycle.
  - count == 1, mode_reg=1: count<=period_reg, stay RUN, done[i]=1 for one cycle.
- RUN with timer_tick=0: count holds.
- IDLE: timer_tick is ignored and count holds.
- Timing:
  - Terminal count occurs exactly N ticks after start; in reload mode, done repeats every N ticks.
  - done is registered and asserted in the same cycle that count shows its new value (0 or period_reg).
  - Changes to N while running do not affect the period; only a new start reloads it.
- Arithmetic:
  - Unsigned, WIDTH bits.
  - N = 2^WIDTH-1 is legal.
  - No wrap below 0: IDLE never decrements, and RUN never holds count 0.
- zero[i] = (count_i == 0), decoded from the register, no extra latency.
- busy[i] = (state == RUN).

Optional Feature:
- Macro: COUNTER_MULTI_CAPTURE_EN.
- Defined:
  - Adds ports: capture in CH; capture_val out CH*WIDTH; capture_valid out CH.
  - capture[i] at an edge: capture_val_i<=count_i (value before that edge's update); capture_valid[i]<=1 the following cycle, sticky.
  - start[i] clears capture_valid[i] unless capture[i] is asserted in the same cycle, in which case capture wins.
  - Reset clears capture_val and capture_valid.
- Undefined:
  - Capture ports and registers are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles -> count=0, busy=0, done=0, zero=1 on all channels; ticks afterward do not change count.
- One-shot, ch0: N=3, reload=0, start, tick every cycle -> count 3,2,1,0; done high exactly one cycle (when count becomes 0); busy drops the same cycle; no further done.
- Auto-reload, ch1: N=4, reload=1, tick every 2nd cycle -> count cycles 4,3,2,1,4,...; done pulses every 8 clks; N changed to 7 mid-run -> period remains 4 until a new start.
- Boundaries: start with N=0 -> IDLE, zero=1, no done. Same-cycle start and stop -> start wins. start during RUN at count=2 with N=9 -> count=9, no done. stop at count=5 -> count frozen at 5, busy=0.
- Independence, CH=4: all channels started with N=1,2,3,4, mixed modes, continuous ticks -> done pulses at ticks 1,2,3,4 respectively; reload channels repeat; rst asserted at tick 3 -> everything clears, no done pulses that cycle.
- With COUNTER_MULTI_CAPTURE_EN: N=10, capture at count=6 -> capture_val=6, capture_valid=1 the next cycle and stays high; a subsequent start -> capture_valid=0.
